// File: rtl/paula_intctl_gen_if.sv
// Register-bus and acknowledge signals between the 68k side and the interrupt controller.
// The master drives address, write data and acknowledge; the slave returns read data.
interface paula_intctl_gen_if;
  logic [8:1]  reg_address_in;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        iack;
  logic [2:0]  iack_level;

  modport master (
    output reg_address_in,
    output data_in,
    output iack,
    output iack_level,
    input  data_out
  );

  modport slave (
    input  reg_address_in,
    input  data_in,
    input  iack,
    input  iack_level,
    output data_out
  );
endinterface

// File: rtl/paula_intctl_gen.sv
// Paula-style interrupt controller: request/enable registers, edge or level capture,
// per-bit level priority with acknowledge auto-clear, registered active-low _ipl.
module paula_intctl_gen #(
  parameter int          NSRC         = 14,
  parameter logic [14:0] EDGE_MASK    = 15'h0000,
  parameter logic [14:0] AUTOCLR_MASK = 15'h0000,
  parameter logic [44:0] LEVELS       = {3'd6, 3'd6, 3'd5, 3'd5, 3'd4, 3'd4, 3'd4, 3'd4,
                                         3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd1, 3'd1},
  parameter logic [8:0]  INTENAR      = 9'h01c,
  parameter logic [8:0]  INTREQR      = 9'h01e,
  parameter logic [8:0]  INTENA       = 9'h09a,
  parameter logic [8:0]  INTREQ       = 9'h09c
) (
  input  logic                clk,
  input  logic                clk7_en,
  input  logic                _reset,
  paula_intctl_gen_if.slave   bus,
  input  logic [NSRC-1:0]     src_in,
  output logic [14:0]         req_mirror,
  output logic                irq_valid,
  output logic [3:0]          irq_src,
  output logic [2:0]          _ipl
);

  logic [14:0]     intena_r;
  logic [14:0]     intreq_r;
  logic [NSRC-1:0] src_d_r;
  logic [2:0]      ipl_r;
  logic [3:0]      irq_src_r;
  logic            irq_valid_r;

  logic [14:0]     src_ext_s;
  logic [14:0]     src_d_ext_s;
  logic [14:0]     hw_s;
  logic [14:0]     ena_next_s;
  logic [14:0]     tmp_s;
  logic [14:0]     req_next_s;
  logic [14:0]     act_s;
  logic            ack_hit_s;
  logic [2:0]      best_lvl_s;
  logic [3:0]      best_idx_s;

  function automatic logic [2:0] level_of(input logic [3:0] idx);
    logic [2:0] lvl;
    if (idx < 4'd15) begin
      lvl = LEVELS[6'(idx) * 6'd3 +: 3];
    end else begin
      lvl = 3'd0;
    end
    return lvl;
  endfunction

  // Software-only bits above NSRC read as permanently low sources.
  assign src_ext_s   = {{(15-NSRC){1'b0}}, src_in};
  assign src_d_ext_s = {{(15-NSRC){1'b0}}, src_d_r};
  assign hw_s        = src_ext_s & ~(EDGE_MASK & src_d_ext_s);

  // Next-state for enable/request: writes, acknowledge auto-clear, then hardware sets on top.
  always_comb begin
    ena_next_s = intena_r;
    tmp_s      = intreq_r;
    ack_hit_s  = 1'b0;

    if (bus.reg_address_in == INTENA[8:1]) begin
      if (bus.data_in[15]) begin
        ena_next_s = intena_r | bus.data_in[14:0];
      end else begin
        ena_next_s = intena_r & ~bus.data_in[14:0];
      end
    end else begin
      ena_next_s = intena_r;
    end

    if (bus.reg_address_in == INTREQ[8:1]) begin
      if (bus.data_in[15]) begin
        tmp_s = intreq_r | bus.data_in[14:0];
      end else begin
        tmp_s = intreq_r & ~bus.data_in[14:0];
      end
    end else begin
      tmp_s = intreq_r;
    end

    ack_hit_s = bus.iack && irq_valid_r && (level_of(irq_src_r) == bus.iack_level)
                && AUTOCLR_MASK[irq_src_r];
    if (ack_hit_s) begin
      tmp_s = tmp_s & ~(15'h0001 << irq_src_r);
    end else begin
      tmp_s = tmp_s;
    end

    req_next_s = tmp_s | hw_s;
  end

  // Priority search; the >= comparison lets the higher index win a level tie.
  always_comb begin
    logic [2:0] lvl;
    act_s      = intena_r[14] ? (intreq_r & intena_r) : 15'h0000;
    best_lvl_s = 3'd0;
    best_idx_s = irq_src_r;
    lvl        = 3'd0;
    for (int i = 0; i < 15; i++) begin
      lvl = LEVELS[i*3 +: 3];
      if (act_s[i] && (lvl != 3'd0) && (lvl >= best_lvl_s)) begin
        best_lvl_s = lvl;
        best_idx_s = 4'(i);
      end else begin
        best_lvl_s = best_lvl_s;
        best_idx_s = best_idx_s;
      end
    end
  end

  // Controller state and registered CPU-facing outputs, frozen while clk7_en is low.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      intena_r    <= 15'h0000;
      intreq_r    <= 15'h0000;
      src_d_r     <= '0;
      ipl_r       <= 3'b111;
      irq_src_r   <= 4'd0;
      irq_valid_r <= 1'b0;
    end else if (clk7_en) begin
      intena_r <= ena_next_s;
      intreq_r <= req_next_s;
      src_d_r  <= src_in;
      if (best_lvl_s != 3'd0) begin
        ipl_r       <= ~best_lvl_s;
        irq_src_r   <= best_idx_s;
        irq_valid_r <= 1'b1;
      end else begin
        ipl_r       <= 3'b111;
        irq_src_r   <= irq_src_r;
        irq_valid_r <= 1'b0;
      end
    end
  end

  // Register readback; reads carry no side effects.
  always_comb begin
    case (bus.reg_address_in)
      INTENAR[8:1]: bus.data_out = {1'b0, intena_r};
      INTREQR[8:1]: bus.data_out = {1'b0, intreq_r};
      default:      bus.data_out = 16'h0000;
    endcase
  end

  assign req_mirror = intreq_r;
  assign irq_valid  = irq_valid_r;
  assign irq_src    = irq_src_r;
  assign _ipl       = ipl_r;

endmodule

// File: tb/tb_paula_intctl_gen.sv
// Vector table with a scoreboard queue, plus hand-written async-reset and edge-at-release sequences.
module tb_paula_intctl_gen;

  localparam logic [7:0] A_ENA  = 8'h4d;
  localparam logic [7:0] A_REQ  = 8'h4e;
  localparam logic [7:0] A_ENAR = 8'h0e;
  localparam logic [7:0] A_REQR = 8'h0f;
  localparam logic [7:0] A_IDLE = 8'h00;
  localparam int NV = 27;

  logic        clk;
  logic        clk7_en;
  logic        _reset;
  logic [13:0] src_in;
  logic [14:0] req_mirror;
  logic        irq_valid;
  logic [3:0]  irq_src;
  logic [2:0]  _ipl;

  int n_tests;
  int n_fail;

  paula_intctl_gen_if bus();

  paula_intctl_gen #(
    .NSRC(14),
    .EDGE_MASK(15'h0002),
    .AUTOCLR_MASK(15'h0020)
  ) dut (
    .clk(clk),
    .clk7_en(clk7_en),
    ._reset(_reset),
    .bus(bus),
    .src_in(src_in),
    .req_mirror(req_mirror),
    .irq_valid(irq_valid),
    .irq_src(irq_src),
    ._ipl(_ipl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [7:0]  addr;
    logic [15:0] din;
    logic [13:0] src;
    logic        iack;
    logic [2:0]  ilvl;
    logic [15:0] dout;
    logic [2:0]  ipl;
    logic [3:0]  isrc;
    logic        valid;
    logic [14:0] mirror;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] dout;
    logic [2:0]  ipl;
    logic [3:0]  isrc;
    logic        valid;
    logic [14:0] mirror;
  } exp_t;

  vec_t vec[NV];
  exp_t exp_q[$];

  function automatic vec_t mk(logic en, logic [7:0] addr, logic [15:0] din, logic [13:0] src,
                              logic iack, logic [2:0] ilvl, logic [15:0] dout, logic [2:0] ipl,
                              logic [3:0] isrc, logic valid, logic [14:0] mirror);
    vec_t v;
    v.en = en; v.addr = addr; v.din = din; v.src = src; v.iack = iack; v.ilvl = ilvl;
    v.dout = dout; v.ipl = ipl; v.isrc = isrc; v.valid = valid; v.mirror = mirror;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    n_tests = 0;
    n_fail  = 0;

    //              en  addr    din       src       ak  lv    dout      ipl     src    v     mirror
    vec[0]  = mk(1'b1, A_ENA,  16'hC008, 14'h0000, 1'b0, 3'd0, 16'h0000, 3'b111, 4'd0,  1'b0, 15'h0000);
    vec[1]  = mk(1'b1, A_REQR, 16'h0000, 14'h0008, 1'b0, 3'd0, 16'h0008, 3'b111, 4'd0,  1'b0, 15'h0008);
    vec[2]  = mk(1'b1, A_REQR, 16'h0000, 14'h0000, 1'b0, 3'd0, 16'h0008, 3'b101, 4'd3,  1'b1, 15'h0008);
    vec[3]  = mk(1'b1, A_ENAR, 16'h0000, 14'h0000, 1'b0, 3'd0, 16'h4008, 3'b101, 4'd3,  1'b1, 15'h0008);
    vec[4]  = mk(1'b1, A_ENA,  16'hA000, 14'h0000, 1'b0, 3'd0, 16'h0000, 3'b101, 4'd3,  1'b1, 15'h0008);
    vec[5]  = mk(1'b1, A_REQR, 16'h0000, 14'h2008, 1'b0, 3'd0, 16'h2008, 3'b101, 4'd3,  1'b1, 15'h2008);
    vec[6]  = mk(1'b1, A_REQR, 16'h0000, 14'h0000, 1'b0, 3'd0, 16'h2008, 3'b001, 4'd13, 1'b1, 15'h2008);
    vec[7]  = mk(1'b1, A_REQ,  16'h2000, 14'h0000, 1'b0, 3'd0, 16'h0000, 3'b001, 4'd13, 1'b1, 15'h0008);
    vec[8]  = mk(1'b1, A_REQR, 16'h0000, 14'h0000, 1'b0, 3'd0, 16'h0008, 3'b101, 4'd3,  1'b1, 15'h0008);
    vec[9]  = mk(1'b1, A_ENA,  16'h8002, 14'h0002, 1'b0, 3'd0, 16'h0000, 3'b101, 4'd3,  1'b1, 15'h000A);
    vec[10] = mk(1'b1, A_REQ,  16'h0002, 14'h0002, 1'b0, 3'd0, 16'h0000, 3'b101, 4'd3,  1'b1, 15'h0008);
    vec[11] = mk(1'b1, A_REQR, 16'h0000, 14'h0002, 1'b0, 3'd0, 16'h0008, 3'b101, 4'd3,  1'b1, 15'h0008);
    vec[12] = mk(1'b1, A_REQR, 16'h0000, 14'h0000, 1'b0, 3'd0, 16'h0008, 3'b101, 4'd3,  1'b1, 15'h0008);
    vec[13] = mk(1'b1, A_REQR, 16'h0000, 14'h0002, 1'b0, 3'd0, 16'h000A, 3'b101, 4'd3,  1'b1, 15'h000A);
    vec[14] = mk(1'b1, A_REQ,  16'h000A, 14'h0000, 1'b0, 3'd0, 16'h0000, 3'b101, 4'd3,  1'b1, 15'h0000);
    vec[15] = mk(1'b1, A_REQR, 16'h0000, 14'h0000, 1'b0, 3'd0, 16'h0000, 3'b111, 4'd3,  1'b0, 15'h0000);
    vec[16] = mk(1'b1, A_ENA,  16'h8020, 14'h0000, 1'b0, 3'd0, 16'h0000, 3'b111, 4'd3,  1'b0, 15'h0000);
    vec[17] = mk(1'b1, A_REQ,  16'h8020, 14'h0000, 1'b0, 3'd0, 16'h0000, 3'b111, 4'd3,  1'b0, 15'h0020);
    vec[18] = mk(1'b1, A_REQR, 16'h0000, 14'h0000, 1'b0, 3'd0, 16'h0020, 3'b100, 4'd5,  1'b1, 15'h0020);
    vec[19] = mk(1'b1, A_REQR, 16'h0000, 14'h0000, 1'b1, 3'd4, 16'h0020, 3'b100, 4'd5,  1'b1, 15'h0020);
    vec[20] = mk(1'b1, A_REQR, 16'h0000, 14'h0000, 1'b1, 3'd3, 16'h0000, 3'b100, 4'd5,  1'b1, 15'h0000);
    vec[21] = mk(1'b1, A_REQR, 16'h0000, 14'h0000, 1'b0, 3'd0, 16'h0000, 3'b111, 4'd5,  1'b0, 15'h0000);
    vec[22] = mk(1'b1, A_REQ,  16'h0080, 14'h0080, 1'b0, 3'd0, 16'h0000, 3'b111, 4'd5,  1'b0, 15'h0080);
    vec[23] = mk(1'b1, A_REQR, 16'h0000, 14'h0000, 1'b0, 3'd0, 16'h0080, 3'b111, 4'd5,  1'b0, 15'h0080);
    vec[24] = mk(1'b1, A_REQ,  16'h0080, 14'h0000, 1'b0, 3'd0, 16'h0000, 3'b111, 4'd5,  1'b0, 15'h0000);
    vec[25] = mk(1'b0, A_REQ,  16'h8004, 14'h0080, 1'b0, 3'd0, 16'h0000, 3'b111, 4'd5,  1'b0, 15'h0000);
    vec[26] = mk(1'b1, A_REQR, 16'h0000, 14'h0000, 1'b0, 3'd0, 16'h0000, 3'b111, 4'd5,  1'b0, 15'h0000);

    _reset             = 1'b0;
    clk7_en            = 1'b1;
    src_in             = 14'h0000;
    bus.reg_address_in = A_IDLE;
    bus.data_in        = 16'h0000;
    bus.iack           = 1'b0;
    bus.iack_level     = 3'd0;
    step();
    step();
    chk("reset ipl", 32'(_ipl), 32'h7);
    chk("reset valid", 32'(irq_valid), 32'h0);
    chk("reset src", 32'(irq_src), 32'h0);
    chk("reset mirror", 32'(req_mirror), 32'h0);
    _reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      clk7_en            = vec[i].en;
      bus.reg_address_in = vec[i].addr;
      bus.data_in        = vec[i].din;
      src_in             = vec[i].src;
      bus.iack           = vec[i].iack;
      bus.iack_level     = vec[i].ilvl;
      e.idx = i; e.dout = vec[i].dout; e.ipl = vec[i].ipl; e.isrc = vec[i].isrc;
      e.valid = vec[i].valid; e.mirror = vec[i].mirror;
      exp_q.push_back(e);
      step();
      e = exp_q.pop_front();
      chk($sformatf("v%0d data_out", e.idx), 32'(bus.data_out), 32'(e.dout));
      chk($sformatf("v%0d ipl", e.idx), 32'(_ipl), 32'(e.ipl));
      chk($sformatf("v%0d irq_src", e.idx), 32'(irq_src), 32'(e.isrc));
      chk($sformatf("v%0d irq_valid", e.idx), 32'(irq_valid), 32'(e.valid));
      chk($sformatf("v%0d req_mirror", e.idx), 32'(req_mirror), 32'(e.mirror));
    end

    // Raise a level-5 request, then pull reset between clock edges.
    clk7_en = 1'b1;
    bus.iack = 1'b0;
    src_in = 14'h0000;
    bus.reg_address_in = A_ENA;
    bus.data_in = 16'h9000;
    step();
    bus.reg_address_in = A_REQ;
    bus.data_in = 16'h9000;
    step();
    bus.reg_address_in = A_IDLE;
    step();
    chk("pre-reset ipl", 32'(_ipl), 32'h2);
    chk("pre-reset src", 32'(irq_src), 32'd12);
    #2;
    _reset = 1'b0;
    #1;
    chk("async ipl", 32'(_ipl), 32'h7);
    chk("async valid", 32'(irq_valid), 32'h0);
    chk("async src", 32'(irq_src), 32'h0);
    chk("async mirror", 32'(req_mirror), 32'h0);
    bus.reg_address_in = A_ENAR;
    #1;
    chk("async intena", 32'(bus.data_out), 32'h0);

    // Edge-mode source already high when reset releases counts as one edge.
    src_in = 14'h0002;
    bus.reg_address_in = A_IDLE;
    #1;
    _reset = 1'b1;
    step();
    chk("release edge", 32'(req_mirror), 32'h0002);
    bus.reg_address_in = A_REQ;
    bus.data_in = 16'h0002;
    step();
    chk("edge clear", 32'(req_mirror), 32'h0000);
    bus.reg_address_in = A_IDLE;
    step();
    step();
    chk("edge held", 32'(req_mirror), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/paula_intctl_gen.md
# paula_intctl_gen

Parametrised Paula-style interrupt controller for the Minimig chipset bus. It collects up to 15 request bits from hardware sources and software writes, and gates them with an enable register and a master enable. It prioritises them through a per-bit level map and drives the registered active-low 68k `_ipl` lines. Compared with the fixed controller it adds per-source edge/level capture, a CPU acknowledge handshake with per-bit auto-clear, and a registered winning-source index for vectoring and debug.

## Interface
- `NSRC`, 14: number of hardware-driven request bits, 1..14. Bits `NSRC`..14 are software-only.
- `EDGE_MASK`, 15'h0000: per bit. 1 = capture on rising edge of `src_in`; 0 = level, OR-ed in every enabled cycle.
- `AUTOCLR_MASK`, 15'h0000: per bit. 1 = bit is cleared by a matching acknowledge.
- `LEVELS`, {6,6,5,5,4,4,4,4,3,3,3,2,1,1,1}: 15×3-bit map, bit 14 in the MSBs. Gives the CPU level per bit; 0 = never interrupts.
- `INTENAR`/`INTREQR`/`INTENA`/`INTREQ`, 9'h01c/9'h01e/9'h09a/9'h09c: register addresses.
- `clk  in  1`: bus clock.
- `clk7_en  in  1`: clock enable. All state advances only when high.
- `_reset  in  1`: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `reg_address_in  in  8 [8:1]`: register address. A write occurs when the address matches on an enabled cycle.
- `data_in  in  16`: write data. Bit 15 = SET(1)/CLR(0); bits 14:0 = mask.
- `data_out  out  16`: read data. Combinational; 0 unless address is INTENAR/INTREQR.
- `src_in  in  NSRC`: hardware request inputs.
- `iack  in  1`: CPU interrupt acknowledge strobe, sampled on enabled cycles.
- `iack_level  in  3`: level being acknowledged.
- `req_mirror  out  15`: `intreq` contents, for SERDATR/audio mirrors.
- `irq_valid  out  1`: registered. An enabled request at level ≥1 exists.
- `irq_src  out  4`: registered index of the winning bit.
- `_ipl  out  3`: registered, active-low level.

## Operation
- State: `intena[14:0]`, `intreq[14:0]`, `src_d[NSRC-1:0]`, and output registers.
- INTENA write:
  - SET: `intena |= data_in[14:0]`.
  - CLR: `intena &= ~data_in[14:0]`.
- INTREQ write applies the same SET/CLR rule to `intreq`, giving `tmp`. Otherwise `tmp = intreq`.
- Hardware capture, for bit i < NSRC:
  - `hw[i] = EDGE_MASK[i] ? src_in[i] & ~src_d[i] : src_in[i]`.
  - `src_d <= src_in` every enabled cycle.
- Acknowledge: on `iack` with `irq_valid=1` and `LEVELS[irq_src]==iack_level`:
  - If `AUTOCLR_MASK[irq_src]`, clear that single bit in `tmp`.
  - Otherwise no effect. `iack` at a non-matching level is ignored.
- Update: `intreq <= tmp | hw`. A set (hardware or software) always wins over a clear (write or ack) of the same bit in the same cycle.
- Masking: `act = intena[14] ? intreq & intena : 0`. Bit 14 is both master enable and an ordinary level-6 request bit.
- Priority:
  - Winner = bit with the highest `LEVELS` value among `act` bits with level ≥1.
  - Ties resolve to the highest bit index.
  - Register `_ipl <= ~level`, `irq_src <= index`, `irq_valid <= 1`.
  - No winner: `_ipl <= 3'b111`, `irq_valid <= 0`, `irq_src` holds its value.
- Readback: `{1'b0, intena}` at INTENAR, `{1'b0, intreq}` at INTREQR. Reads have no side effects.

## Timing
- Reset (async assert, clocked release): `intena`, `intreq`, `src_d`, `irq_src`, `irq_valid` = 0; `_ipl` = 3'b111; `req_mirror` = 0.
- An input already high at release is seen as an edge on the first enabled cycle.
- Cycles with `clk7_en=0` freeze all state, including edge history. A pulse that is high only while `clk7_en=0` is lost.
- Latency: source high on enabled cycle N → `intreq` set after N → `_ipl`/`irq_src`/`irq_valid` update after the next enabled cycle (N+1). The same applies to write-driven changes.
- Level-mode bits re-set every cycle while the input is high; a clear does not stick until the input drops.
- Edge-mode bits set exactly once per rising edge.
- Simultaneous INTREQ CLR and matching ack on the same bit: cleared once; no extra effect.
- `_reset` asserted mid-operation: outputs go to reset values immediately, without waiting for `clk`.

## Test plan
- Reset, then write INTENA 16'hC008 and pulse `src_in[3]` (level mode) for one enabled cycle → INTREQR reads 16'h0008, `_ipl`=3'b101 two enabled cycles later, `irq_src`=3.
- Enable bits 3 and 13 plus master; raise both → `_ipl`=3'b001, `irq_src`=13. Write INTREQ 16'h2000 → `_ipl`=3'b101, `irq_src`=3.
- `EDGE_MASK[1]=1`: hold `src_in[1]` high 10 cycles and clear via INTREQ 16'h0002 → bit stays 0 until a new 0→1 transition.
- `AUTOCLR_MASK[5]=1`, bit 5 pending and enabled → `iack` with `iack_level=3` clears bit 5 and `_ipl` returns to 3'b111; `iack_level=4` leaves it set.
- Same-cycle INTREQ 16'h0080 (clear) with `src_in[7]` high → bit 7 remains set. Toggle `clk7_en` low during a pulse → no state change.
- Assert `_reset` asynchronously while `_ipl`=3'b010 → `_ipl`=3'b111 and all registers 0 before the next `clk` edge.
